// File: rtl/calc_sched.sv
// Command scheduler between the UART hex parser and the multiply/divide ALU.
// Queues commands, screens illegal ones, times out the ALU and holds results on valid/ready.
module calc_sched #(
    parameter int DEPTH       = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        parser_done,
    input  logic [3:0]  dtype,
    input  logic [4:0]  operator,
    input  logic [15:0] src1,
    input  logic [15:0] src2,
    output logic        cmd_drop,
    output logic        alu_start,
    output logic [3:0]  alu_dtype,
    output logic [4:0]  alu_op,
    output logic [15:0] alu_src1,
    output logic [15:0] alu_src2,
    input  logic        alu_done,
    input  logic [31:0] alu_res,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [1:0]  res_err,
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_OUT
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_DIVZERO = 2'd1;
    localparam logic [1:0] ERR_UNSUPP  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [31:0]     res_data_q, res_data_d;
    logic [1:0]      res_err_q, res_err_d;
    logic            cmd_drop_q;

    logic [40:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;

    logic [3:0]  alu_dtype_q;
    logic [4:0]  alu_op_q;
    logic [15:0] alu_src1_q, alu_src2_q;

    logic        push, pop;
    logic [40:0] head;
    logic [3:0]  head_dtype;
    logic [4:0]  head_op;
    logic [15:0] head_src1, head_src2;
    logic        head_unsupported, head_divzero;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop  = (state_q == S_IDLE) && (count_q != '0);
    assign push = parser_done && ((count_q != CW'(DEPTH)) || pop);

    assign head = mem_q[rd_ptr_q];
    assign {head_dtype, head_op, head_src1, head_src2} = head;
    assign head_unsupported = !((head_dtype == 4'd1) || (head_dtype == 4'd2)) ||
                              !((head_op == 5'd3) || (head_op == 5'd4));
    assign head_divzero     = (head_op == 5'd4) && (head_src2 == 16'd0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {dtype, operator, src1, src2};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cmd_drop_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            cmd_drop_q <= parser_done && !push;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            alu_dtype_q <= '0;
            alu_op_q    <= '0;
            alu_src1_q  <= '0;
            alu_src2_q  <= '0;
        end else if (pop) begin
            alu_dtype_q <= head_dtype;
            alu_op_q    <= head_op;
            alu_src1_q  <= head_src1;
            alu_src2_q  <= head_src2;
        end
    end

    // The ISSUE cycle counts as the first waited cycle, so a timeout lands
    // exactly TIMEOUT_CYC cycles after alu_start.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    if (head_unsupported) begin
                        res_data_d = '0;
                        res_err_d  = ERR_UNSUPP;
                        state_d    = S_OUT;
                    end else if (head_divzero) begin
                        res_data_d = '0;
                        res_err_d  = ERR_DIVZERO;
                        state_d    = S_OUT;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                timer_d = TW'(1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                if (alu_done) begin
                    res_data_d = alu_res;
                    res_err_d  = ERR_OK;
                    state_d    = S_OUT;
                end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                    res_data_d = '0;
                    res_err_d  = ERR_TIMEOUT;
                    state_d    = S_OUT;
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            res_data_q <= '0;
            res_err_q  <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
        end
    end

    assign cmd_drop  = cmd_drop_q;
    assign alu_start = (state_q == S_ISSUE);
    assign alu_dtype = alu_dtype_q;
    assign alu_op    = alu_op_q;
    assign alu_src1  = alu_src1_q;
    assign alu_src2  = alu_src2_q;
    assign res_valid = (state_q == S_OUT);
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;
    assign busy      = (count_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_calc_sched.sv
// Scoreboard bench for calc_sched: stimulus pushes expected results, a negedge
// monitor checks every presented result against the queue head.
module tb_calc_sched;

    localparam int DEPTH = 2;
    localparam int TO    = 64;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        parser_done = 1'b0;
    logic [3:0]  dtype = '0;
    logic [4:0]  operator = '0;
    logic [15:0] src1 = '0;
    logic [15:0] src2 = '0;
    logic        alu_done = 1'b0;
    logic [31:0] alu_res = '0;
    logic        res_ready = 1'b0;
    logic        cmd_drop, alu_start, res_valid, busy;
    logic [3:0]  alu_dtype;
    logic [4:0]  alu_op;
    logic [15:0] alu_src1, alu_src2;
    logic [31:0] res_data;
    logic [1:0]  res_err;

    calc_sched #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .n_rst(n_rst), .parser_done(parser_done), .dtype(dtype),
        .operator(operator), .src1(src1), .src2(src2), .cmd_drop(cmd_drop),
        .alu_start(alu_start), .alu_dtype(alu_dtype), .alu_op(alu_op),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_done(alu_done),
        .alu_res(alu_res), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  err;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int issueCyc = 0;
    int startCount = 0, lastStartCyc = -1, lastValidCyc = -1, dropCount = 0;
    logic prevValid = 1'b0;

    logic aluHang = 1'b0;
    int aluDelay = 3;
    int lateReq = 0, lateSeen = 0;
    logic [31:0] aluCalc;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] aluModel(input logic [3:0] dt, input logic [4:0] op,
                                              input logic [15:0] a, input logic [15:0] b);
        logic [31:0] r;
        r = '0;
        if (op == 5'd3) begin
            if (dt == 4'd1) r = 32'($signed(a) * $signed(b));
            else            r = {16'd0, a} * {16'd0, b};
        end else if (op == 5'd4 && b != 16'd0) begin
            r = {a % b, a / b};
        end
        return r;
    endfunction

    // Monitor: every cycle a result is presented it must match the scoreboard head.
    always @(negedge clk) begin
        if (alu_start) begin
            startCount++;
            lastStartCyc = cyc;
        end
        if (cmd_drop) dropCount++;
        if (res_valid && !prevValid) lastValidCyc = cyc;
        if (res_valid) begin
            if (sbq.size() == 0) begin
                checkOutput("unexpected_res_valid", 32'd1, 32'd0);
            end else begin
                checkOutput("res_data", res_data, sbq[0].data);
                checkOutput("res_err", {30'd0, res_err}, {30'd0, sbq[0].err});
                if (res_ready) void'(sbq.pop_front());
            end
        end
        prevValid = res_valid;
    end

    // ALU model: answers a start after aluDelay cycles unless hung; can also
    // inject a stray completion on request.
    initial begin
        forever begin
            @(negedge clk);
            if (alu_start && !aluHang) begin
                aluCalc = aluModel(alu_dtype, alu_op, alu_src1, alu_src2);
                repeat (aluDelay) @(posedge clk);
                #1 alu_done = 1'b1;
                alu_res = aluCalc;
                @(posedge clk);
                #1 alu_done = 1'b0;
                alu_res = '0;
            end else if (lateReq != lateSeen) begin
                lateSeen = lateReq;
                @(posedge clk);
                #1 alu_done = 1'b1;
                alu_res = 32'hDEADBEEF;
                @(posedge clk);
                #1 alu_done = 1'b0;
                alu_res = '0;
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] dt, input logic [4:0] op,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic [31:0] expData, input logic [1:0] expErr,
                                 input bit expectResult);
        @(posedge clk);
        #1;
        parser_done = 1'b1;
        dtype = dt;
        operator = op;
        src1 = a;
        src2 = b;
        issueCyc = cyc;
        if (expectResult) sbq.push_back('{data: expData, err: expErr});
    endtask

    task automatic endStimulus();
        @(posedge clk);
        #1 parser_done = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input int maxCyc);
        for (int i = 0; i < maxCyc && sbq.size() != 0; i++) @(posedge clk);
        #1;
        checkOutput("drain_timeout", 32'(sbq.size()), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ctrl"}, {28'd0, cmd_drop, alu_start, res_valid, busy}, 32'd0);
        checkOutput({tag, "_alu_srcs"}, {alu_src1, alu_src2}, 32'd0);
        checkOutput({tag, "_alu_ctl"}, {23'd0, alu_dtype, alu_op}, 32'd0);
        checkOutput({tag, "_res_data"}, res_data, 32'd0);
        checkOutput({tag, "_res_err"}, {30'd0, res_err}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int s0, d0, w;
        res_ready = 1'b1;
        waitCycles(3);
        checkAllZero("reset");
        @(negedge clk) n_rst = 1'b1;

        $display("[TB] signed multiply");
        aluDelay = 3;
        s0 = startCount;
        applyStimulus(4'd1, 5'd3, 16'hFFFE, 16'h0003, 32'hFFFFFFFA, 2'd0, 1'b1);
        endStimulus();
        waitDrain(50);
        checkOutput("mul_start_count", 32'(startCount - s0), 32'd1);
        checkOutput("mul_start_latency", 32'(lastStartCyc - issueCyc), 32'd2);
        checkOutput("mul_done_latency", 32'(lastValidCyc - lastStartCyc), 32'(aluDelay + 1));
        waitCycles(2);
        checkOutput("mul_busy_after", {31'd0, busy}, 32'd0);

        $display("[TB] divide by zero");
        s0 = startCount;
        applyStimulus(4'd2, 5'd4, 16'h0064, 16'h0000, 32'd0, 2'd1, 1'b1);
        endStimulus();
        waitDrain(20);
        checkOutput("div0_no_start", 32'(startCount - s0), 32'd0);
        checkOutput("div0_latency", 32'(lastValidCyc - issueCyc), 32'd2);

        $display("[TB] unsupported commands");
        s0 = startCount;
        applyStimulus(4'd3, 5'd3, 16'h0001, 16'h0002, 32'd0, 2'd2, 1'b1);
        endStimulus();
        waitDrain(20);
        checkOutput("unsup_latency", 32'(lastValidCyc - issueCyc), 32'd2);
        applyStimulus(4'd1, 5'd1, 16'h0001, 16'h0002, 32'd0, 2'd2, 1'b1);
        endStimulus();
        waitDrain(20);
        checkOutput("unsup_no_start", 32'(startCount - s0), 32'd0);

        $display("[TB] timeout");
        aluHang = 1'b1;
        applyStimulus(4'd1, 5'd3, 16'h0002, 16'h0003, 32'd0, 2'd3, 1'b1);
        endStimulus();
        waitDrain(TO + 20);
        checkOutput("timeout_latency", 32'(lastValidCyc - lastStartCyc), 32'(TO));
        lateReq++;
        waitCycles(6);
        checkOutput("late_done_ignored", {30'd0, busy, res_valid}, 32'd0);
        aluHang = 1'b0;

        $display("[TB] queueing, drop and hold");
        aluDelay = 20;
        res_ready = 1'b0;
        applyStimulus(4'd2, 5'd3, 16'h0010, 16'h0020, 32'h00000200, 2'd0, 1'b1);
        endStimulus();
        waitCycles(3);
        d0 = dropCount;
        applyStimulus(4'd2, 5'd4, 16'h0064, 16'h0007, 32'h0002000E, 2'd0, 1'b1);
        applyStimulus(4'd1, 5'd3, 16'h0100, 16'hFFFF, 32'hFFFFFF00, 2'd0, 1'b1);
        applyStimulus(4'd2, 5'd3, 16'h0005, 16'h0005, 32'd0, 2'd0, 1'b0);
        endStimulus();
        waitCycles(2);
        checkOutput("drop_count", 32'(dropCount - d0), 32'd1);
        w = 0;
        while (!res_valid && w < 100) begin
            waitCycles(1);
            w++;
        end
        checkOutput("first_valid_seen", {31'd0, res_valid}, 32'd1);
        waitCycles(10);
        checkOutput("hold_valid", {31'd0, res_valid}, 32'd1);
        res_ready = 1'b1;
        waitDrain(200);
        waitCycles(2);
        checkOutput("queue_busy_after", {31'd0, busy}, 32'd0);

        $display("[TB] reset mid-wait");
        aluHang = 1'b1;
        applyStimulus(4'd2, 5'd3, 16'h0001, 16'h0002, 32'd0, 2'd0, 1'b0);
        endStimulus();
        waitCycles(3);
        applyStimulus(4'd2, 5'd3, 16'h0003, 16'h0004, 32'd0, 2'd0, 1'b0);
        applyStimulus(4'd1, 5'd3, 16'h0005, 16'h0006, 32'd0, 2'd0, 1'b0);
        endStimulus();
        waitCycles(2);
        checkOutput("pre_reset_busy", {31'd0, busy}, 32'd1);
        #2 n_rst = 1'b0;
        #1;
        checkAllZero("midreset");
        waitCycles(2);
        @(negedge clk) n_rst = 1'b1;
        s0 = startCount;
        lateReq++;
        waitCycles(20);
        checkOutput("post_reset_no_start", 32'(startCount - s0), 32'd0);
        checkOutput("post_reset_idle", {30'd0, busy, res_valid}, 32'd0);
        aluHang = 1'b0;

        checkOutput("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
